// File: rtl/addr_dec_ws.sv
// addr_dec_ws: memory-map decoder and bus-cycle sequencer.
// Decodes the upper SEL_W address bits into one-hot active-low chip selects,
// inserts a per-region number of wait states, and ends each access with a
// one-cycle READY pulse (populated region) or BERR pulse (unpopulated region).
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST    in   asynchronous active-high reset
//   ADDR   in   access address, sampled on acceptance in IDLE
//   REQ    in   access request, sampled only in IDLE
//   RW     in   1 = read, 0 = write, sampled with ADDR
//   CS_N   out  active-low one-hot chip selects
//   OE_N   out  active-low output enable (reads)
//   WE_N   out  active-low write enable (writes)
//   READY  out  one-cycle completion pulse
//   BERR   out  one-cycle bus-error pulse
//   BUSY   out  high whenever the sequencer is not idle
module addr_dec_ws #(
  parameter int unsigned           ADDR_W   = 16,
  parameter int unsigned           SEL_W    = 3,
  parameter int unsigned           NCS      = 1 << SEL_W,
  parameter int unsigned           WAIT_W   = 4,
  parameter logic [NCS-1:0]        POP_MASK = NCS'(8'b0101_0100),
  parameter logic [NCS*WAIT_W-1:0] WAITS    = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              REQ,
  input  logic              RW,
  output logic [NCS-1:0]    CS_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic              READY,
  output logic              BERR,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   region_q, region_d;
  logic               rw_q, rw_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]   region_in;

  logic [NCS-1:0]     cs_n_d;
  logic               oe_n_d, we_n_d, ready_d, berr_d, busy_d;

  // Only the region bits of the address take part in decoding.
  logic unused_addr_low;
  assign unused_addr_low = ^ADDR[ADDR_W-SEL_W-1:0];

  assign region_in = ADDR[ADDR_W-1 -: SEL_W];

  // State, latched access attributes and all outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      region_q <= '0;
      rw_q     <= 1'b0;
      cnt_q    <= '0;
      CS_N     <= '1;
      OE_N     <= 1'b1;
      WE_N     <= 1'b1;
      READY    <= 1'b0;
      BERR     <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      rw_q     <= rw_d;
      cnt_q    <= cnt_d;
      CS_N     <= cs_n_d;
      OE_N     <= oe_n_d;
      WE_N     <= we_n_d;
      READY    <= ready_d;
      BERR     <= berr_d;
      BUSY     <= busy_d;
    end
  end

  // Next state, plus next output values derived from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    rw_d     = rw_q;
    cnt_d    = cnt_q;
    cs_n_d   = '1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    ready_d  = 1'b0;
    berr_d   = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          region_d = region_in;
          rw_d     = RW;
          cnt_d    = WAITS[int'(region_in) * WAIT_W +: WAIT_W];
          state_d  = POP_MASK[region_in] ? S_ACCESS : S_ERR;
        end
      end
      S_ACCESS: begin
        // Counter reaching zero ends the wait period; it never wraps.
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - WAIT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_ACCESS, S_DONE: begin
        cs_n_d  = ~(NCS'(1) << region_d);
        oe_n_d  = ~rw_d;
        we_n_d  = rw_d;
        ready_d = (state_d == S_DONE);
      end
      S_ERR:   berr_d = 1'b1;
      default: ;
    endcase
  end

endmodule
